// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic operand feeder.
//   DATA_WIDTH : operand width per lane
//   SIZE       : array rows = columns = lanes per edge
//   K_MAX      : deepest inner dimension a tile may use (buffer depth)
package systolic_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int SIZE       = 4;
  localparam int K_MAX      = 16;

  // Counter width covers the longest FEED sweep without wrapping.
  localparam int CNT_W  = $clog2(K_MAX + SIZE);
  localparam int KLEN_W = $clog2(K_MAX + 1);

  typedef logic [SIZE-1:0][DATA_WIDTH-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/skew_operand_buffer.sv
// Operand store for one array edge: K_MAX entries of SIZE lanes, one write
// port, and SIZE combinational diagonal read ports.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : entry written (beat index k)
//   wr_data_i  : SIZE lanes of beat k
//   rd_t_i     : wavefront index t
//   k_len_i    : number of valid entries
//   rd_data_o  : lane l = entry (t-l) lane l, zero when out of range
//   rd_vld_o   : lane l in range (0 <= t-l < k_len)
module skew_operand_buffer
  import systolic_pkg::*;
(
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [CNT_W-1:0]           wr_addr_i,
  input  logic [SIZE*DATA_WIDTH-1:0] wr_data_i,
  input  logic [CNT_W-1:0]           rd_t_i,
  input  logic [KLEN_W-1:0]          k_len_i,
  output logic [SIZE*DATA_WIDTH-1:0] rd_data_o,
  output logic [SIZE-1:0]            rd_vld_o
);

  localparam int AW = $clog2(K_MAX);

  // Contents are only read under an in-range flag, so no reset is needed.
  lane_vec_t mem_q [K_MAX];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[AW'(wr_addr_i)] <= wr_data_i;
  end

  for (genvar l = 0; l < SIZE; l++) begin : g_lane
    logic [CNT_W-1:0] off;
    logic             hit;

    assign off = rd_t_i - CNT_W'(l);
    // off < k_len <= K_MAX whenever hit is set, so the truncated index is exact.
    assign hit = (rd_t_i >= CNT_W'(l)) && (off < CNT_W'(k_len_i));

    assign rd_vld_o[l]                             = hit;
    assign rd_data_o[l*DATA_WIDTH +: DATA_WIDTH]   = hit ? mem_q[AW'(off)][l] : '0;
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Transmit side of the SIZE x SIZE output-stationary MAC array. Buffers one
// tile of A columns / B rows, then drives the west and north edges with
// diagonally skewed wavefronts, pulses acc_clear first and done at the end.
//   clk, rst_n            : clock, async active-low reset
//   cfg_valid/ready/k_len : tile configuration handshake
//   op_valid/ready/a/b    : operand beats (column k of A, row k of B)
//   west_a/west_vld       : row-edge operands, lane i to row i
//   north_b/north_vld     : column-edge operands, lane j to column j
//   acc_clear             : one-cycle accumulator clear in the first FEED cycle
//   busy, done, err       : status; err qualifies done on a bad k_len
//
// state | meaning
// IDLE  | waiting for a tile config
// LOAD  | storing k_len operand beats
// FEED  | sweeping wavefronts t = 0..k_len+SIZE-2 onto the edges
// DRAIN | waiting for the last product to reach the far-corner PE
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [KLEN_W-1:0]          cfg_k_len,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [SIZE*DATA_WIDTH-1:0] op_a,
  input  logic [SIZE*DATA_WIDTH-1:0] op_b,
  output logic [SIZE*DATA_WIDTH-1:0] west_a,
  output logic [SIZE-1:0]            west_vld,
  output logic [SIZE*DATA_WIDTH-1:0] north_b,
  output logic [SIZE-1:0]            north_vld,
  output logic                       acc_clear,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(SIZE - 2 + PIPE_LAT);

  feeder_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [KLEN_W-1:0] k_len_q, k_len_d;
  logic done_q, done_d, err_q, err_d, clr_q, clr_d;
  logic wr_en;

  logic [SIZE*DATA_WIDTH-1:0] a_rd, b_rd, wa_q, wa_d, nb_q, nb_d;
  logic [SIZE-1:0]            a_vld, b_vld, wv_q, wv_d, nv_q, nv_d;

  skew_operand_buffer u_buf_a (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (cnt_q),
    .wr_data_i (op_a),
    .rd_t_i    (cnt_q),
    .k_len_i   (k_len_q),
    .rd_data_o (a_rd),
    .rd_vld_o  (a_vld)
  );

  skew_operand_buffer u_buf_b (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (cnt_q),
    .wr_data_i (op_b),
    .rd_t_i    (cnt_q),
    .k_len_i   (k_len_q),
    .rd_data_o (b_rd),
    .rd_vld_o  (b_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_len_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      wa_q    <= '0;
      wv_q    <= '0;
      nb_q    <= '0;
      nv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_len_q <= k_len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      wa_q    <= wa_d;
      wv_q    <= wv_d;
      nb_q    <= nb_d;
      nv_q    <= nv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_len_d = k_len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr_d   = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if ((cfg_k_len != '0) && (cfg_k_len <= KLEN_W'(K_MAX))) begin
            k_len_d = cfg_k_len;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (op_valid) begin
          wr_en = 1'b1;
          if (cnt_q == CNT_W'(k_len_q) - CNT_W'(1)) begin
            cnt_d   = '0;
            clr_d   = 1'b1;
            state_d = FEED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FEED: begin
        if (cnt_q == CNT_W'(k_len_q) + CNT_W'(SIZE - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Wavefront t = cnt_q is registered, so it reaches the edge one cycle later.
  // The final FEED count (t = k_len+SIZE-1) is out of range on every lane,
  // which leaves the edges at zero going into DRAIN.
  always_comb begin
    wa_d = '0;
    wv_d = '0;
    nb_d = '0;
    nv_d = '0;
    if (state_q == FEED) begin
      wa_d = a_rd;
      wv_d = a_vld;
      nb_d = b_rd;
      nv_d = b_vld;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign op_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign acc_clear = clr_q;
  assign west_a    = wa_q;
  assign west_vld  = wv_q;
  assign north_b   = nb_q;
  assign north_vld = nv_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
module tb_systolic_operand_feeder;

  localparam int DW = 32;
  localparam int SZ = 4;
  localparam int KM = 16;
  localparam int PL = 2;

  logic clk, rst_n;
  logic cfg_valid, cfg_ready;
  logic [4:0] cfg_k_len;
  logic op_valid, op_ready;
  logic [SZ*DW-1:0] op_a, op_b, west_a, north_b;
  logic [SZ-1:0] west_vld, north_vld;
  logic acc_clear, busy, done, err;

  systolic_operand_feeder #(.PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_k_len(cfg_k_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .west_a(west_a), .west_vld(west_vld), .north_b(north_b), .north_vld(north_vld),
    .acc_clear(acc_clear), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [SZ*DW-1:0] wa;
    logic [SZ-1:0]    wv;
    logic [SZ*DW-1:0] nb;
    logic [SZ-1:0]    nv;
    logic clr, busy, done, err, rdy, oprdy;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  logic [DW-1:0] am [SZ][KM];
  logic [DW-1:0] bm [KM][SZ];

  // Array model: operands hop one PE per cycle east/south.
  logic [DW-1:0] pa [SZ][SZ];
  logic [DW-1:0] pb [SZ][SZ];
  logic          pav[SZ][SZ];
  logic          pbv[SZ][SZ];
  logic [DW-1:0] acc[SZ][SZ];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t gen(input int c, input int k);
    exp_t e;
    int t, feed_len, drain_end;
    e = '0;
    feed_len  = k + SZ;
    drain_end = feed_len + SZ - 1 + PL;
    if (c < feed_len) begin
      e.busy = 1'b1;
      e.clr  = (c == 0);
      if (c >= 1) begin
        t = c - 1;
        for (int i = 0; i < SZ; i++) begin
          if (t - i >= 0 && t - i < k) begin
            e.wv[i] = 1'b1;
            e.wa[i*DW +: DW] = am[i][t-i];
            e.nv[i] = 1'b1;
            e.nb[i*DW +: DW] = bm[t-i][i];
          end
        end
      end
    end else if (c < drain_end) begin
      e.busy = 1'b1;
    end else if (c == drain_end) begin
      e.done = 1'b1;
      e.rdy  = 1'b1;
    end else begin
      e.rdy = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("west_a", west_a, e.wa);
        chk("west_vld", west_vld, e.wv);
        chk("north_b", north_b, e.nb);
        chk("north_vld", north_vld, e.nv);
        chk("acc_clear", acc_clear, e.clr);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("err", err, e.err);
        chk("cfg_ready", cfg_ready, e.rdy);
        chk("op_ready", op_ready, e.oprdy);
      end
    end
  end

  // Array model update
  initial begin
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        pa[i][j] = '0; pb[i][j] = '0; pav[i][j] = 1'b0; pbv[i][j] = 1'b0; acc[i][j] = '0;
      end
    forever begin
      @(negedge clk);
      for (int i = SZ-1; i >= 0; i--)
        for (int j = SZ-1; j >= 0; j--) begin
          pa[i][j]  = (j == 0) ? west_a[i*DW +: DW] : pa[i][j-1];
          pav[i][j] = (j == 0) ? west_vld[i]        : pav[i][j-1];
          pb[i][j]  = (i == 0) ? north_b[j*DW +: DW] : pb[i-1][j];
          pbv[i][j] = (i == 0) ? north_vld[j]        : pbv[i-1][j];
        end
      for (int i = 0; i < SZ; i++)
        for (int j = 0; j < SZ; j++) begin
          if (acc_clear) acc[i][j] = '0;
          else if (pav[i][j] && pbv[i][j]) acc[i][j] = acc[i][j] + pa[i][j] * pb[i][j];
        end
    end
  end

  task automatic run_tile(input int k, input logic [31:0] pat, input int plen,
                          input bit inject, input int rst_at);
    int beat, idx, c;
    logic v;
    chk("cfg_ready_pre", cfg_ready, 1'b1);
    cfg_k_len = 5'(k);
    cfg_valid = 1'b1;
    op_valid  = 1'b1;             // beat outside LOAD must be ignored
    op_a      = '1;
    op_b      = '1;
    tick();
    cfg_valid = 1'b0;
    beat = 0;
    idx  = 0;
    while (beat < k && idx < 200) begin
      v = (idx < plen) ? pat[idx] : 1'b1;
      op_valid = v;
      for (int i = 0; i < SZ; i++) begin
        op_a[i*DW +: DW] = v ? am[i][beat] : 32'hdead_0000 + 32'(idx);
        op_b[i*DW +: DW] = v ? bm[beat][i] : 32'hbeef_0000 + 32'(idx);
      end
      chk("op_ready_load", op_ready, 1'b1);
      tick();
      if (v) beat++;
      idx++;
    end
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    for (int cc = 0; cc <= k + 2*SZ - 1 + PL + 1; cc++) sb.push_back(gen(cc, k));
    c = 0;
    while (sb.size() > 0 && c < 200) begin
      if (inject) begin
        cfg_valid = (c == 2);
        cfg_k_len = 5'd1;
      end
      if (c == rst_at) begin
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_west_a", west_a, '0);
        chk("rst_north_b", north_b, '0);
        chk("rst_vld", {west_vld, north_vld}, '0);
        chk("rst_flags", {busy, done, err, acc_clear, op_ready, cfg_ready}, 6'b000001);
      end
      tick();
      c++;
    end
    cfg_valid = 1'b0;
    if (sb.size() > 0) chk("sb_timeout", sb.size(), 0);
  endtask

  task automatic err_cfg(input int k);
    cfg_k_len = 5'(k);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("err_done", {done, err}, 2'b11);
    chk("err_quiet", {busy, acc_clear, west_vld, north_vld}, '0);
    tick();
    chk("err_pulse", {done, err, busy}, 3'b000);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_k_len = '0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    #3;
    chk("reset_edges", {west_a, north_b, west_vld, north_vld}, '0);
    chk("reset_flags", {busy, done, err, acc_clear, op_ready, cfg_ready}, 6'b000001);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("idle_quiet", {busy, done, acc_clear, op_ready, west_vld, north_vld}, '0);
    end

    // k_len = 1
    for (int i = 0; i < SZ; i++) begin
      am[i][0] = 32'(i + 1);
      bm[0][i] = 32'(i + 5);
    end
    run_tile(1, '0, 0, 1'b0, -1);

    // k_len = 4, A = identity, B = 1..16
    for (int i = 0; i < SZ; i++)
      for (int kk = 0; kk < SZ; kk++) begin
        am[i][kk] = (i == kk) ? 32'd1 : 32'd0;
        bm[kk][i] = 32'(kk*SZ + i + 1);
      end
    nd = n_done;
    run_tile(4, '0, 0, 1'b0, -1);
    chk("done_once", n_done - nd, 1);
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++)
        chk($sformatf("sum%0d%0d", i, j), acc[i][j], bm[i][j]);

    // k_len = 3 with op_valid pattern 1,0,0,1,0,1 and a cfg pulse during FEED
    for (int i = 0; i < SZ; i++)
      for (int kk = 0; kk < 3; kk++) begin
        am[i][kk] = $urandom;
        bm[kk][i] = $urandom;
      end
    run_tile(3, 32'b101001, 6, 1'b1, -1);

    err_cfg(0);
    err_cfg(17);

    // reset at F3 of a k_len = 4 tile
    for (int i = 0; i < SZ; i++)
      for (int kk = 0; kk < 4; kk++) begin
        am[i][kk] = $urandom;
        bm[kk][i] = $urandom;
      end
    run_tile(4, '0, 0, 1'b0, 3);
    tick();
    rst_n = 1'b1;
    nd = n_done;
    for (int n = 0; n < 20; n++) tick();
    chk("no_done_after_rst", n_done - nd, 0);
    chk("idle_after_rst", {busy, cfg_ready}, 2'b01);

    for (int i = 0; i < SZ; i++)
      for (int kk = 0; kk < 2; kk++) begin
        am[i][kk] = $urandom;
        bm[kk][i] = $urandom;
      end
    nd = n_done;
    run_tile(2, '0, 0, 1'b0, -1);
    chk("done_after_rst_tile", n_done - nd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Transmit side of the 4x4 output-stationary MAC array.
- Buffers one tile's A columns and B rows, then drives the array's west (A) and north (B) edges with diagonally skewed wavefronts. Row i and column j are delayed i and j cycles respectively.
- Pulses an accumulator clear before the first wavefront.
- Signals done once the last product has reached the far-corner PE.

Parameters:
- DATA_WIDTH, 32, operand width per lane
- SIZE, 4, array rows = columns = lanes per edge
- K_MAX, 16, maximum inner dimension (buffer depth)
- PIPE_LAT, 2, PE register stages between edge input and accumulator update

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cfg_valid  in  1  tile config request
- cfg_ready  out  1  high only in IDLE
- cfg_k_len  in  $clog2(K_MAX+1)  inner dimension K
- op_valid  in  1  operand beat valid
- op_ready  out  1  high only in LOAD
- op_a  in  SIZE*DATA_WIDTH  column k of A; lane i = A[i][k]
- op_b  in  SIZE*DATA_WIDTH  row k of B; lane j = B[k][j]
- west_a  out  SIZE*DATA_WIDTH  row-edge operands, lane i to row i
- west_vld  out  SIZE  per-lane valid
- north_b  out  SIZE*DATA_WIDTH  column-edge operands, lane j to column j
- north_vld  out  SIZE  per-lane valid
- acc_clear  out  1  one-cycle accumulator clear
- busy  out  1  high in LOAD/FEED/DRAIN
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; bad k_len

Behaviour:
- Reset is asynchronous, active-low: rst_n; clock clk. All outputs reset to 0, except cfg_ready = 1. State resets to IDLE and counters to 0.
- States: IDLE, LOAD, FEED, DRAIN.
- IDLE:
  - cfg handshake (cfg_valid & cfg_ready) with 1 ≤ k_len ≤ K_MAX latches k_len and goes to LOAD.
  - Any other k_len: stay IDLE; next cycle done = 1, err = 1. No acc_clear, no valids.
- LOAD:
  - Each op handshake writes op_a/op_b to buffer index kcnt, then kcnt++.
  - op_valid gaps stall with no side effects.
  - Accepting beat k_len-1 transitions to FEED.
- FEED:
  - F0 is the first FEED cycle. acc_clear = 1 during F0 only.
  - Wavefront counter t = 0..k_len+SIZE-2. Wavefront t is registered and visible in cycle F(t+1).
  - West lane i: west_vld[i] = (0 ≤ t-i < k_len), west_a lane = A[i][t-i].
  - North lane j: north_vld[j] = (0 ≤ t-j < k_len), north_b lane = B[t-j][j].
  - Invalid lanes drive data 0.
  - FEED lasts k_len+SIZE cycles, then goes to DRAIN with all valids/data 0.
- DRAIN:
  - Lasts SIZE-1+PIPE_LAT cycles.
  - On exit: state → IDLE and done = 1 (err = 0) for exactly one cycle. cfg_ready rises in that same cycle.
- The next tile may be configured in the done cycle.
- cfg_valid while busy is ignored (cfg_ready = 0). Operand beats outside LOAD are ignored.
- Reset mid-operation: outputs go to 0 immediately. FSM is in IDLE after release, buffer contents are discarded, and no done is issued.
- Data passes through unmodified; no arithmetic on operands. Counters are sized $clog2(K_MAX+SIZE) and never wrap within a tile.

Decomposition:
- Package systolic_pkg holds:
  - DATA_WIDTH, SIZE, K_MAX constants
  - lane_vec_t typedef (SIZE x DATA_WIDTH packed)
  - feeder_state_t enum {IDLE, LOAD, FEED, DRAIN}
- Sub-module skew_operand_buffer:
  - K_MAX x lane_vec_t register file, one write port.
  - SIZE combinational diagonal read ports: lane l reads entry t-l, with an in-range flag.
  - Instantiated twice, for A and for B.
- The top holds the FSM, counters and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0, cfg_ready=1. After release, no activity without cfg.
- k_len=1, op_a={1,2,3,4}, op_b={5,6,7,8}:
  - acc_clear at F0.
  - west lane i = i+1 and north lane j = j+5, each valid only at F(i+1) / F(j+1).
  - done 10 cycles after F0.
- k_len=4, A=identity, B=1..16, with an array model:
  - west_a lane i = A[i][k] at F(k+i+1).
  - Final array sums = B. done exactly once.
- LOAD backpressure: k_len=3 with op_valid toggling 1,0,0,1,0,1 -> 3 beats stored in order; FEED starts the cycle after the 3rd handshake. cfg_valid pulsed during FEED is ignored.
- cfg_k_len=0 and cfg_k_len=17 -> done=err=1 one cycle later; busy, acc_clear and all valids stay 0.
- rst_n low at F3 of a k_len=4 tile -> outputs 0 immediately, no done. A new k_len=2 tile afterward completes correctly.
